// File: rtl/buscador_pkg.sv
// Shared types and default sizes for the buscador_extremos min/max burst search block.
package buscador_pkg;

    localparam int N_DEFECTO = 4;
    localparam int L_DEFECTO = 8;

    typedef enum logic [2:0] {
        INACTIVO,
        RECIBE,
        CMP_MAX,
        CMP_MIN,
        FIN
    } estado_t;

endpackage

// File: rtl/buscador_extremos_if.sv
// Burst data/result bundle for buscador_extremos.
// Optional index outputs exist only when BUSCADOR_EXTREMOS_INDICE_EN is defined.
interface buscador_extremos_if #(
    parameter int N = buscador_pkg::N_DEFECTO,
    parameter int L = buscador_pkg::L_DEFECTO
) ();
    localparam int LW = $clog2(L + 1);

    logic          start;
    logic [LW-1:0] len;
    logic [N-1:0]  dato;
    logic          dato_valido;
    logic          dato_listo;
    logic [N-1:0]  maximo;
    logic [N-1:0]  minimo;
    logic          ocupado;
    logic          listo;
    logic          vacio;
`ifdef BUSCADOR_EXTREMOS_INDICE_EN
    logic [LW-1:0] idx_max;
    logic [LW-1:0] idx_min;
`endif

    modport slave (
`ifdef BUSCADOR_EXTREMOS_INDICE_EN
        output idx_max, idx_min,
`endif
        input  start, len, dato, dato_valido,
        output dato_listo, maximo, minimo, ocupado, listo, vacio
    );

    modport master (
`ifdef BUSCADOR_EXTREMOS_INDICE_EN
        input  idx_max, idx_min,
`endif
        output start, len, dato, dato_valido,
        input  dato_listo, maximo, minimo, ocupado, listo, vacio
    );

endinterface

// File: rtl/buscador_extremos_comparador.sv
// Unsigned magnitude comparator; exactly one of igual/menor/mayor is high.
module comparador #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         igual,
    output logic         menor,
    output logic         mayor
);
    assign igual = (a == b);
    assign menor = (a < b);
    assign mayor = (a > b);
endmodule

// File: rtl/buscador_extremos.sv
// Running max/min over a burst of up to L unsigned words, one shared comparator.
// Define BUSCADOR_EXTREMOS_INDICE_EN to also track the burst position of each extreme.
module buscador_extremos
    import buscador_pkg::*;
#(
    parameter int N = N_DEFECTO,
    parameter int L = L_DEFECTO
) (
    input  logic                     clk,
    input  logic                     rst,
    buscador_extremos_if.slave       bus
);
    localparam int LW = $clog2(L + 1);

    estado_t       estado_q, estado_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  d_q, d_d;
    logic [N-1:0]  max_q, max_d;
    logic [N-1:0]  min_q, min_d;
`ifdef BUSCADOR_EXTREMOS_INDICE_EN
    logic [LW-1:0] idx_max_q, idx_max_d;
    logic [LW-1:0] idx_min_q, idx_min_d;
`endif

    logic [LW-1:0] len_sat;
    logic [LW-1:0] cnt_inc;
    logic [N-1:0]  cmp_b;
    logic          igual, menor, mayor;

    assign len_sat = (bus.len > LW'(L)) ? LW'(L) : bus.len;
    assign cnt_inc = cnt_q + LW'(1);
    // The comparator's b side follows whichever extreme is being tested this cycle.
    assign cmp_b   = (estado_q == CMP_MIN) ? min_q : max_q;

    comparador #(.N(N)) u_comparador (
        .a     (d_q),
        .b     (cmp_b),
        .igual (igual),
        .menor (menor),
        .mayor (mayor)
    );

    always_comb begin
        estado_d  = estado_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        d_d       = d_q;
        max_d     = max_q;
        min_d     = min_q;
`ifdef BUSCADOR_EXTREMOS_INDICE_EN
        idx_max_d = idx_max_q;
        idx_min_d = idx_min_q;
`endif
        case (estado_q)
            INACTIVO: begin
                if (bus.start) begin
                    len_d = len_sat;
                    cnt_d = '0;
                    if (len_sat == '0) begin
                        max_d    = '0;
                        min_d    = '0;
                        estado_d = FIN;
                    end else begin
                        estado_d = RECIBE;
                    end
                end
            end
            RECIBE: begin
                if (bus.dato_valido) begin
                    if (cnt_q == '0) begin
                        // First word seeds both extremes without a comparison.
                        max_d = bus.dato;
                        min_d = bus.dato;
                        cnt_d = LW'(1);
`ifdef BUSCADOR_EXTREMOS_INDICE_EN
                        idx_max_d = '0;
                        idx_min_d = '0;
`endif
                        estado_d = (len_q == LW'(1)) ? FIN : RECIBE;
                    end else begin
                        d_d      = bus.dato;
                        estado_d = CMP_MAX;
                    end
                end
            end
            CMP_MAX: begin
                if (mayor) begin
                    max_d = d_q;
`ifdef BUSCADOR_EXTREMOS_INDICE_EN
                    idx_max_d = cnt_q;
`endif
                end
                estado_d = CMP_MIN;
            end
            CMP_MIN: begin
                if (menor) begin
                    min_d = d_q;
`ifdef BUSCADOR_EXTREMOS_INDICE_EN
                    idx_min_d = cnt_q;
`endif
                end
                cnt_d    = cnt_inc;
                estado_d = (cnt_inc == len_q) ? FIN : RECIBE;
            end
            FIN:     estado_d = INACTIVO;
            default: estado_d = INACTIVO;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q  <= INACTIVO;
            len_q     <= '0;
            cnt_q     <= '0;
            d_q       <= '0;
            max_q     <= '0;
            min_q     <= '0;
`ifdef BUSCADOR_EXTREMOS_INDICE_EN
            idx_max_q <= '0;
            idx_min_q <= '0;
`endif
        end else begin
            estado_q  <= estado_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            d_q       <= d_d;
            max_q     <= max_d;
            min_q     <= min_d;
`ifdef BUSCADOR_EXTREMOS_INDICE_EN
            idx_max_q <= idx_max_d;
            idx_min_q <= idx_min_d;
`endif
        end
    end

    assign bus.dato_listo = (estado_q == RECIBE);
    assign bus.ocupado    = (estado_q != INACTIVO);
    assign bus.listo      = (estado_q == FIN);
    assign bus.vacio      = (estado_q == FIN) && (len_q == '0);
    assign bus.maximo     = max_q;
    assign bus.minimo     = min_q;
`ifdef BUSCADOR_EXTREMOS_INDICE_EN
    assign bus.idx_max    = idx_max_q;
    assign bus.idx_min    = idx_min_q;
`endif

endmodule

// File: tb/tb_buscador_extremos.sv
// Directed bench for buscador_extremos: bursts, ties, empty burst, reset mid-burst, clamping.
module tb_buscador_extremos;
    localparam int N  = 4;
    localparam int L  = 8;
    localparam int LW = $clog2(L + 1);

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [N-1:0] wv [16];
    int           gv [16];

    always #5 clk = ~clk;

    buscador_extremos_if #(.N(N), .L(L)) bus ();
    buscador_extremos #(.N(N), .L(L)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_tables();
        for (int i = 0; i < 16; i++) begin
            wv[i] = '0;
            gv[i] = 0;
        end
    endtask

    // Runs one burst; cyc = rising edges from the start edge until listo is seen.
    task automatic run_burst(input string nm, input int l, input int nw, input bit mid_start,
                             input bit exp_vacio, output int cyc);
        int budget;
        cyc = 0;
        bus.start = 1'b1;
        bus.len   = LW'(l);
        tick();
        bus.start = 1'b0;
        bus.len   = '0;
        cyc = 1;
        for (int i = 0; i < nw; i++) begin
            bus.dato_valido = 1'b0;
            budget = 0;
            @(negedge clk);
            while (!bus.dato_listo && budget < 10) begin
                tick(); cyc++; budget++;
                @(negedge clk);
            end
            if (bus.dato_listo !== 1'b1) begin
                checks++; errors++;
                $display("FAIL %s wait_dato_listo word %0d got %b want 1", nm, i, bus.dato_listo);
                return;
            end
            for (int g = 0; g < gv[i]; g++) begin
                if (mid_start) begin
                    bus.start = 1'b1;
                    bus.len   = '0;
                end
                tick(); cyc++;
                bus.start = 1'b0;
            end
            if (gv[i] > 0) begin
                @(negedge clk);
                checks++;
                if (bus.dato_listo !== 1'b1 || bus.ocupado !== 1'b1) begin
                    errors++;
                    $display("FAIL %s gap_hold word %0d got listo=%b ocupado=%b want 1 1",
                             nm, i, bus.dato_listo, bus.ocupado);
                end
            end
            bus.dato        = wv[i];
            bus.dato_valido = 1'b1;
            tick(); cyc++;
        end
        bus.dato_valido = 1'b0;
        budget = 0;
        @(negedge clk);
        while (!bus.listo && budget < 40) begin
            tick(); cyc++; budget++;
            @(negedge clk);
        end
        checks++;
        if (bus.listo !== 1'b1) begin
            errors++;
            $display("FAIL %s listo_timeout got %b want 1", nm, bus.listo);
            return;
        end
        checks++;
        if (bus.vacio !== exp_vacio) begin
            errors++;
            $display("FAIL %s vacio got %b want %b", nm, bus.vacio, exp_vacio);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.listo !== 1'b0 || bus.ocupado !== 1'b0) begin
            errors++;
            $display("FAIL %s listo_one_cycle got listo=%b ocupado=%b want 0 0",
                     nm, bus.listo, bus.ocupado);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0; bus.len = '0; bus.dato = '0; bus.dato_valido = 1'b0;
        #12;
        checks++;
        if ({bus.ocupado, bus.listo, bus.vacio, bus.dato_listo} !== 4'b0000 ||
            bus.maximo !== 4'd0 || bus.minimo !== 4'd0) begin
            errors++;
            $display("FAIL reset_state got oc=%b li=%b va=%b dl=%b max=%0d min=%0d want all 0",
                     bus.ocupado, bus.listo, bus.vacio, bus.dato_listo, bus.maximo, bus.minimo);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int cyc;
        clear_tables();
        wv[0] = 4'd5; wv[1] = 4'd2; wv[2] = 4'd9; wv[3] = 4'd2;
        run_burst("basic", 4, 4, 1'b0, 1'b0, cyc);
        checks++;
        if (cyc !== 11) begin
            errors++; $display("FAIL basic_latency got %0d want 11", cyc);
        end
        checks++;
        if (bus.maximo !== 4'd9 || bus.minimo !== 4'd2) begin
            errors++; $display("FAIL basic_ext got max=%0d min=%0d want 9 2", bus.maximo, bus.minimo);
        end
`ifdef BUSCADOR_EXTREMOS_INDICE_EN
        checks++;
        if (bus.idx_max !== LW'(2) || bus.idx_min !== LW'(1)) begin
            errors++; $display("FAIL basic_idx got %0d %0d want 2 1", bus.idx_max, bus.idx_min);
        end
`endif
    endtask

    task automatic test_single();
        int cyc;
        clear_tables();
        wv[0] = 4'd7;
        run_burst("single", 1, 1, 1'b0, 1'b0, cyc);
        checks++;
        if (cyc !== 2) begin
            errors++; $display("FAIL single_latency got %0d want 2", cyc);
        end
        checks++;
        if (bus.maximo !== 4'd7 || bus.minimo !== 4'd7) begin
            errors++; $display("FAIL single_ext got max=%0d min=%0d want 7 7", bus.maximo, bus.minimo);
        end
    endtask

    task automatic test_empty();
        int cyc;
        run_burst("empty", 0, 0, 1'b0, 1'b1, cyc);
        checks++;
        if (cyc !== 1) begin
            errors++; $display("FAIL empty_latency got %0d want 1", cyc);
        end
        checks++;
        if (bus.maximo !== 4'd0 || bus.minimo !== 4'd0) begin
            errors++; $display("FAIL empty_ext got max=%0d min=%0d want 0 0", bus.maximo, bus.minimo);
        end
    endtask

    task automatic test_ties();
        int cyc;
        clear_tables();
        wv[0] = 4'd4; wv[1] = 4'd4; wv[2] = 4'd4;
        run_burst("ties", 3, 3, 1'b0, 1'b0, cyc);
        checks++;
        if (cyc !== 8) begin
            errors++; $display("FAIL ties_latency got %0d want 8", cyc);
        end
        checks++;
        if (bus.maximo !== 4'd4 || bus.minimo !== 4'd4) begin
            errors++; $display("FAIL ties_ext got max=%0d min=%0d want 4 4", bus.maximo, bus.minimo);
        end
`ifdef BUSCADOR_EXTREMOS_INDICE_EN
        checks++;
        if (bus.idx_max !== LW'(0) || bus.idx_min !== LW'(0)) begin
            errors++; $display("FAIL ties_idx got %0d %0d want 0 0", bus.idx_max, bus.idx_min);
        end
`endif
    endtask

    task automatic test_reset_mid_burst();
        int cyc;
        bus.start = 1'b1; bus.len = LW'(4);
        tick();
        bus.start = 1'b0; bus.len = '0;
        bus.dato = 4'd3; bus.dato_valido = 1'b1;
        tick();
        bus.dato = 4'd8;
        tick();
        bus.dato_valido = 1'b0;
        checks++;
        if (bus.ocupado !== 1'b1 || bus.dato_listo !== 1'b0 || bus.maximo !== 4'd3) begin
            errors++;
            $display("FAIL mid_pre got oc=%b dl=%b max=%0d want 1 0 3",
                     bus.ocupado, bus.dato_listo, bus.maximo);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.ocupado, bus.listo, bus.vacio, bus.dato_listo} !== 4'b0000 ||
            bus.maximo !== 4'd0 || bus.minimo !== 4'd0) begin
            errors++;
            $display("FAIL mid_reset got oc=%b li=%b va=%b dl=%b max=%0d min=%0d want all 0",
                     bus.ocupado, bus.listo, bus.vacio, bus.dato_listo, bus.maximo, bus.minimo);
        end
        tick();
        rst = 1'b0;
        clear_tables();
        wv[0] = 4'd15; wv[1] = 4'd0;
        run_burst("after_reset", 2, 2, 1'b0, 1'b0, cyc);
        checks++;
        if (cyc !== 5) begin
            errors++; $display("FAIL after_reset_latency got %0d want 5", cyc);
        end
        checks++;
        if (bus.maximo !== 4'd15 || bus.minimo !== 4'd0) begin
            errors++; $display("FAIL after_reset_ext got max=%0d min=%0d want 15 0", bus.maximo, bus.minimo);
        end
    endtask

    task automatic test_clamp_gaps();
        int cyc;
        clear_tables();
        wv[0] = 4'd3; wv[1] = 4'd9; wv[2] = 4'd1; wv[3] = 4'd12;
        wv[4] = 4'd6; wv[5] = 4'd0; wv[6] = 4'd15; wv[7] = 4'd7;
        gv[2] = 2; gv[5] = 1;
        run_burst("clamp", 12, 8, 1'b1, 1'b0, cyc);
        checks++;
        if (cyc !== 26) begin
            errors++; $display("FAIL clamp_latency got %0d want 26", cyc);
        end
        checks++;
        if (bus.maximo !== 4'd15 || bus.minimo !== 4'd0) begin
            errors++; $display("FAIL clamp_ext got max=%0d min=%0d want 15 0", bus.maximo, bus.minimo);
        end
`ifdef BUSCADOR_EXTREMOS_INDICE_EN
        checks++;
        if (bus.idx_max !== LW'(6) || bus.idx_min !== LW'(5)) begin
            errors++; $display("FAIL clamp_idx got %0d %0d want 6 5", bus.idx_max, bus.idx_min);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_empty();
        test_ties();
        test_reset_mid_burst();
        test_clamp_gaps();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/buscador_extremos.md
BUSCADOR_EXTREMOS -- requirements
Module: buscador_extremos

Interface
REQ-001 SHALL have parameter N, default 4: data word width in bits.
REQ-002 SHALL have parameter L, default 8: maximum burst length; LW = $clog2(L+1).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a burst; sampled only in INACTIVO.
REQ-006 len  input  LW  burst length, latched with start.
REQ-007 dato  input  N  unsigned data word.
REQ-008 dato_valido  input  1  dato is valid this cycle.
REQ-009 dato_listo  output  1  block accepts dato this cycle.
REQ-010 maximo  output  N  running and final maximum.
REQ-011 minimo  output  N  running and final minimum.
REQ-012 ocupado  output  1  high in every state except INACTIVO.
REQ-013 listo  output  1  one-cycle pulse; maximo/minimo are final.
REQ-014 vacio  output  1  high with listo when the latched len was 0.

Function
REQ-015 States SHALL be INACTIVO, RECIBE, CMP_MAX, CMP_MIN, FIN.
REQ-016 INACTIVO, start=1: latch len (values >L clamped to L), clear count, go RECIBE; latched len=0 goes FIN with vacio=1, maximo=minimo=0.
REQ-017 RECIBE: dato_listo=1; transfer occurs only when dato_valido && dato_listo; otherwise hold state.
REQ-018 First transfer of a burst: maximo<=dato, minimo<=dato, count<=1, no comparison; go FIN if count reaches len, else stay RECIBE.
REQ-019 Later transfers: latch dato into internal register d, go CMP_MAX; dato_listo=0 in CMP_MAX and CMP_MIN.
REQ-020 One comparator instance SHALL be shared: CMP_MAX drives a=d, b=maximo; CMP_MIN drives a=d, b=minimo.
REQ-021 Comparator contract: igual=(a==b), menor=(a<b), mayor=(a>b), exactly one high.
REQ-022 CMP_MAX: mayor=1 -> maximo<=d; go CMP_MIN.
REQ-023 CMP_MIN: menor=1 -> minimo<=d; count<=count+1; go FIN if count+1==len, else RECIBE.
REQ-024 Ties (igual=1) SHALL NOT update maximo/minimo; first occurrence wins.
REQ-025 FIN: listo=1 for exactly one cycle, go INACTIVO; maximo/minimo hold until the next burst's first transfer.
REQ-026 start outside INACTIVO SHALL be ignored; start in FIN is ignored.
REQ-027 Throughput: first word 1 cycle, each later word 3 cycles (RECIBE, CMP_MAX, CMP_MIN) with dato_valido held high.

Reset
REQ-028 rst=1 at any time, including mid-burst, SHALL force INACTIVO and clear maximo, minimo, d, count, latched len; listo=vacio=dato_listo=ocupado=0.
REQ-029 First start accepted on the first rising edge after rst deasserts.

Configuration
REQ-030 With BUSCADOR_EXTREMOS_INDICE_EN defined: add outputs idx_max, idx_min (LW bits, reset 0) holding the 0-based burst position of the current maximum/minimum, written together with maximo/minimo (position 0 on first transfer).
REQ-031 Without BUSCADOR_EXTREMOS_INDICE_EN: those ports and position registers SHALL not exist; all other behaviour identical.

Structure
REQ-032 Package buscador_pkg SHALL hold the state enum typedef and default parameter constants (N, L).
REQ-033 Comparator SHALL be a sub-module named comparador (parameter N; a, b; igual, menor, mayor), instantiated once, inputs muxed by state.

Verification
REQ-034 N=4, len=4, words 5,2,9,2 (valid held) -> listo 1 cycle after 4th word's CMP_MIN; maximo=9, minimo=2; with macro idx_max=2, idx_min=1.
REQ-035 len=1, word 7 -> listo the cycle after transfer; maximo=minimo=7; dato_listo never low while ocupado before FIN.
REQ-036 len=0 -> FIN one cycle after start; listo=vacio=1, maximo=minimo=0.
REQ-037 len=3, words 4,4,4 -> maximo=minimo=4; with macro idx_max=idx_min=0 (tie rule).
REQ-038 len=4, rst asserted in CMP_MAX after 2nd word -> all outputs 0 immediately; new start len=2, words 15,0 -> maximo=15, minimo=0.
REQ-039 len=12 with L=8 -> exactly 8 transfers then listo; start pulsed mid-burst ignored; dato_valido gaps extend RECIBE without state change.
